channel_scan_sequencer: RTL and testbench

CHANNEL_SCAN_SEQUENCER -- requirements
Module: channel_scan_sequencer

---
 rtl/channel_scan_sequencer.sv | 138 +++++++++++++
 tb/tb_channel_scan_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_scan_sequencer.sv
// Channel scan sequencer: steps a 3-bit decoder select through the enabled channels of a
// captured mask, holding each for dwell+1 cycles. Define SCAN_CONTINUOUS_EN for wrap-around scanning.
`timescale 1ns/1ps
module channel_scan_sequencer #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [DWELL_W-1:0] CntOne = DWELL_W'(1);

    state_e             r_state;
    logic [7:0]         r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [2:0]         r_sel;
    logic               r_sel_valid;
    logic               r_busy;
    logic               r_done;

    logic [2:0]         w_first_sel;
    logic [2:0]         w_wrap_sel;
    logic [2:0]         w_next_sel;
    logic               w_has_next;

    function automatic logic [2:0] f_lowest(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign w_first_sel = f_lowest(mask);
    assign w_wrap_sel  = f_lowest(r_mask);

    // Nearest enabled channel strictly above the current one in the captured mask.
    always_comb begin
        w_has_next = 1'b0;
        w_next_sel = r_sel;
        for (int i = 7; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_has_next = 1'b1;
                w_next_sel = 3'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_mask      <= '0;
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_mask  <= mask;
                        r_dwell <= dwell;
                        if (mask != '0) begin
                            r_state     <= StScan;
                            r_sel       <= w_first_sel;
                            r_sel_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_cnt       <= dwell;
                        end else begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end
                    end
                end
                StScan: begin
                    // Abort wins over dwell expiry.
                    if (stop) begin
                        r_state     <= StIdle;
                        r_sel_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CntOne;
                    end else if (w_has_next) begin
                        r_sel <= w_next_sel;
                        r_cnt <= r_dwell;
                    end else begin
`ifdef SCAN_CONTINUOUS_EN
                        r_sel  <= w_wrap_sel;
                        r_cnt  <= r_dwell;
                        r_done <= 1'b1;
`else
                        r_state     <= StDone;
                        r_sel_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
`endif
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

`ifndef SCAN_CONTINUOUS_EN
    logic w_unused_wrap;
    assign w_unused_wrap = ^w_wrap_sel;
`endif

    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Bench for channel_scan_sequencer: queue-based expected-output model plus directed literal checks.
`timescale 1ns/1ps
module tb_channel_scan_sequencer;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [7:0]    mask = '0;
    logic [DW-1:0] dwell = '0;
    logic [2:0]    sel;
    logic          sel_valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    channel_scan_sequencer #(.DWELL_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mask      (mask),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic       valid;
        logic       busy;
        logic       done;
    } out_t;

    // Model: cur is what the outputs must show this cycle; q holds the outputs of future cycles.
    out_t          cur = '0;
    out_t          q[$];
    logic [7:0]    cap_mask = '0;
    logic [DW-1:0] cap_dwell = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_pass(input logic [7:0] m, input logic [DW-1:0] d,
                                      input logic wrap_done, input logic add_done);
        logic       first;
        logic [2:0] last;
        first = 1'b1;
        last  = '0;
        for (int ch = 0; ch < 8; ch++) begin
            if (m[ch]) begin
                for (int k = 0; k <= int'(d); k++) begin
                    q.push_back({3'(ch), 1'b1, 1'b1, wrap_done & first});
                    first = 1'b0;
                end
                last = 3'(ch);
            end
        end
        if (add_done) q.push_back({last, 1'b0, 1'b0, 1'b1});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur = '0;
            q.delete();
        end else if (cur.busy && stop) begin
            q.delete();
            cur.valid = 1'b0;
            cur.busy  = 1'b0;
            cur.done  = 1'b0;
        end else if (q.size() != 0) begin
            cur = q.pop_front();
        end else if (cur.busy) begin
            push_pass(cap_mask, cap_dwell, 1'b1, 1'b0);
            cur = q.pop_front();
        end else if (cur.done) begin
            cur.done = 1'b0;
        end else if (start) begin
            cap_mask  = mask;
            cap_dwell = dwell;
            if (mask == 8'h00) begin
                cur.done = 1'b1;
            end else begin
`ifdef SCAN_CONTINUOUS_EN
                push_pass(mask, dwell, 1'b0, 1'b0);
`else
                push_pass(mask, dwell, 1'b0, 1'b1);
`endif
                cur = q.pop_front();
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("sel", 32'(sel), 32'(cur.sel));
            check("sel_valid", 32'(sel_valid), 32'(cur.valid));
            check("busy", 32'(busy), 32'(cur.busy));
            check("done", 32'(done), 32'(cur.done));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 32'(sel_valid), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
    endtask

    logic [2:0] exp_sel [8];
    logic [2:0] cont_sel [5];
    logic       cont_done [5];
    int         n;
    int         r;

    initial begin
        exp_sel   = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7};
        cont_sel  = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1};
        cont_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        #2;
        check("reset_sel", 32'(sel), 32'd0);
        check_idle("reset");
        tick();
        rst_n = 1'b1;
        tick();

`ifndef SCAN_CONTINUOUS_EN
        // Pattern 1010_0101, dwell 1; mask/dwell/start disturbances mid-scan must be ignored.
        mask = 8'b1010_0101; dwell = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("p27_sel", 32'(sel), 32'(exp_sel[i]));
            check("p27_valid", 32'(sel_valid), 32'd1);
            if (i == 3) begin mask = 8'hFF; dwell = 4'd0; start = 1'b1; end
            if (i == 5) start = 1'b0;
            tick();
        end
        check("p27_done", 32'(done), 32'd1);
        check("p27_done_valid", 32'(sel_valid), 32'd0);
        check("p27_done_sel", 32'(sel), 32'd7);
        tick();
        check_idle("p27_after");
        tick();

        mask = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        check("p28_done", 32'(done), 32'd1);
        check("p28_valid", 32'(sel_valid), 32'd0);
        tick();
        check_idle("p28_after");

        mask = 8'hFF; dwell = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("p29_sel", 32'(sel), 32'd3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("p29_stop");
        tick();
        check("p29_no_done", 32'(done), 32'd0);

        mask = 8'h80; dwell = 4'd15; start = 1'b1;
        tick();
        start = 1'b0;
        check("p30_sel", 32'(sel), 32'd7);
        n = 0;
        while (sel_valid && n < 40) begin
            n++;
            tick();
        end
        check("p30_hold_cycles", 32'(n), 32'd16);
        check("p30_done", 32'(done), 32'd1);
        tick();
`else
        mask = 8'b0000_0110; dwell = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("cont_sel", 32'(sel), 32'(cont_sel[i]));
            check("cont_done", 32'(done), 32'(cont_done[i]));
            check("cont_busy", 32'(busy), 32'd1);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("cont_stop");
        tick();
`endif

        // Asynchronous reset mid-scan, then restart from the lowest enabled channel.
        mask = 8'b0011_0100; dwell = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        check("p31_sel", 32'(sel), 32'd0);
        check_idle("p31_reset");
        #2 rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("p31_restart_sel", 32'(sel), 32'd2);
        check("p31_restart_valid", 32'(sel_valid), 32'd1);

        for (int it = 0; it < 600; it++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 7);
            if (r == 0)      mask = 8'h00;
            else if (r == 1) mask = 8'(1 << $urandom_range(0, 7));
            else             mask = 8'($urandom);
            dwell = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
